// File: rtl/coherence_bus_ctrl.sv
// MSI snooping bus controller between two dcaches and shared RAM: arbitrates
// coherence requests and victim writebacks, issues snoops, sequences 2-word fills.
module coherence_bus_ctrl #(
    parameter int CPUS  = 2,
    parameter int WORDS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_SNOOP,
        S_ACK,
        S_MEM,
        S_C2C
    } state_t;

    localparam logic LAST_W = 1'(WORDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_g;
    logic        r_w;
    logic        r_last;
    logic        w_g_next;
    logic        w_w_next;
    logic        w_last_next;
    logic        w_o;
    logic        w_gsel;
    logic        w_access;
    logic [1:0]  w_req;
    logic [31:0] w_blk_addr;

    assign w_o        = ~r_g;
    assign w_req      = cctrans | dWEN;
    // Ties go to the core that was not granted last; otherwise the lone requester.
    assign w_gsel     = (&w_req) ? ~r_last : w_req[1];
    assign w_access   = (ramstate == 2'b10);
    assign w_blk_addr = {daddr[r_g][31:3], r_w, 2'b00};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_g     <= 1'b0;
            r_w     <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_g     <= w_g_next;
            r_w     <= w_w_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_g_next     = r_g;
        w_w_next     = r_w;
        w_last_next  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_g_next     = w_gsel;
                    w_last_next  = w_gsel;
                    w_w_next     = 1'b0;
                    w_state_next = cctrans[w_gsel] ? S_SNOOP : S_WB;
                end
            end
            S_WB: begin
                if (w_access) w_state_next = S_IDLE;
            end
            S_SNOOP: begin
                if (cctrans[w_o]) begin
                    if (ccwrite[w_o])    w_state_next = S_C2C;
                    else if (dREN[r_g])  w_state_next = S_MEM;
                    else                 w_state_next = S_ACK;
                end
            end
            S_ACK: w_state_next = S_IDLE;
            S_MEM, S_C2C: begin
                if (w_access) begin
                    if (r_w == LAST_W) w_state_next = S_IDLE;
                    else               w_w_next     = r_w + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state plus the live bus/core inputs.
    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        unique case (r_state)
            S_WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_g];
                ramstore = dstore[r_g];
                if (w_access) dwait[r_g] = 1'b0;
            end
            S_SNOOP: begin
                ccwait[w_o]      = 1'b1;
                ccinv[w_o]       = ccwrite[r_g];
                ccsnoopaddr[w_o] = w_blk_addr;
            end
            S_ACK: begin
                ccwait[w_o]      = 1'b1;
                ccsnoopaddr[w_o] = w_blk_addr;
                dwait[r_g]       = 1'b0;
            end
            S_MEM: begin
                ccwait[w_o]      = 1'b1;
                ccsnoopaddr[w_o] = w_blk_addr;
                ramREN           = 1'b1;
                ramaddr          = w_blk_addr;
                dload[r_g]       = ramload;
                if (w_access) dwait[r_g] = 1'b0;
            end
            S_C2C: begin
                // Dirty snooper feeds the requester and RAM in the same cycle.
                ccwait[w_o]      = 1'b1;
                ccinv[w_o]       = ccwrite[r_g];
                ccsnoopaddr[w_o] = w_blk_addr;
                dload[r_g]       = dstore[w_o];
                ramWEN           = 1'b1;
                ramaddr          = w_blk_addr;
                ramstore         = dstore[w_o];
                if (w_access) dwait = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: transactions push expected word
// completions; a monitor pops one entry per dwait pulse and compares.
module tb_coherence_bus_ctrl;

    localparam int K_RD  = 0;
    localparam int K_UPG = 1;
    localparam int K_WB  = 2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    coherence_bus_ctrl #(.CPUS(2), .WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  dw;
        int          core;
        bit          chk_load;
        logic [31:0] load;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        m_last = 1'b1;
    logic [31:0] mem [logic [31:0]];
    int          lat_left   = 0;
    int          lat_fixed  = -1;
    int          stall_mode = 2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] dw, input int core, input bit cl,
                            input logic [31:0] load, input logic ren, input logic wen,
                            input logic [31:0] addr, input logic [31:0] store);
        exp_t e;
        e.dw = dw; e.core = core; e.chk_load = cl; e.load = load;
        e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic next_lat();
        lat_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endtask

    // RAM model: stalls for lat_left cycles, then one ACCESS cycle per word.
    task automatic env_drive();
        if (ramREN || ramWEN) begin
            if (lat_left > 0) begin
                lat_left--;
                case (stall_mode)
                    0:       ramstate = 2'b01;
                    1:       ramstate = 2'b11;
                    default: ramstate = ($urandom_range(0, 2) == 0) ? 2'b11 :
                                        ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
                endcase
            end else begin
                ramstate = 2'b10;
                next_lat();
            end
        end else begin
            ramstate = 2'b00;
        end
        ramload = ram_rd(ramaddr);
    endtask

    task automatic clear_inputs();
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        sb.delete();
        nRST   = 1'b1;
        m_last = 1'b1;
    endtask

    task automatic run_txn(input int c, input int kind, input logic [31:0] addr, input logic excl,
                           input logic [31:0] wdata, input logic [31:0] s0, input logic [31:0] s1,
                           input logic dirty, input int abort_at);
        int          o, target, done, resp_dly;
        bit          seen, responded;
        logic [1:0]  mask;
        logic [31:0] wa;
        logic [31:0] snp [2];
        o      = 1 - c;
        mask   = (c == 0) ? 2'b10 : 2'b01;
        snp[0] = s0;
        snp[1] = s1;
        if (kind == K_WB) begin
            target = 1;
            push_exp(mask, c, 0, 0, 1'b0, 1'b1, addr, wdata);
        end else if (kind == K_UPG) begin
            target = 1;
            push_exp(mask, c, 0, 0, 1'b0, 1'b0, 0, 0);
        end else begin
            target = 2;
            for (int w = 0; w < 2; w++) begin
                wa = {addr[31:3], w[0], 2'b00};
                if (dirty) push_exp(2'b00, c, 1, snp[w], 1'b0, 1'b1, wa, snp[w]);
                else       push_exp(mask, c, 1, ram_rd(wa), 1'b1, 1'b0, wa, 0);
            end
        end
        @(negedge CLK);
        dREN[c]    = (kind == K_RD);
        dWEN[c]    = (kind == K_WB);
        cctrans[c] = (kind != K_WB);
        ccwrite[c] = (kind == K_WB) ? 1'b0 : excl;
        daddr[c]   = addr;
        dstore[c]  = wdata;
        done = 0; seen = 0; responded = 0;
        resp_dly = $urandom_range(0, 2);
        next_lat();
        env_drive();
        for (int cyc = 0; cyc < 300 && done < target; cyc++) begin
            @(negedge CLK);
            if (cyc == abort_at) begin
                nRST = 1'b0;
                @(negedge CLK);
                #1;
                chk("abort dwait", dwait, 2'b11);
                chk("abort ram enables", {ramREN, ramWEN}, 2'b00);
                chk("abort ccwait", ccwait, 2'b00);
                clear_inputs();
                sb.delete();
                @(negedge CLK);
                nRST   = 1'b1;
                m_last = 1'b1;
                return;
            end
            chk("ccwait to granted core", ccwait[c], 1'b0);
            if (kind == K_WB) begin
                chk("no snoop on writeback", ccwait[o], 1'b0);
                chk("writeback holds ramWEN", ramWEN, 1'b1);
            end else if (ccwait[o]) begin
                if (!seen) chk("ccinv on snoop", ccinv[o], excl);
                seen = 1;
                chk("ccsnoopaddr", ccsnoopaddr[o], {addr[31:3], done[0], 2'b00});
                if (!responded) begin
                    if (resp_dly == 0) begin
                        cctrans[o] = 1'b1;
                        ccwrite[o] = dirty;
                        responded  = 1;
                    end else begin
                        resp_dly--;
                    end
                end
                dstore[o] = snp[ccsnoopaddr[o][2]];
            end
            if (kind == K_UPG) chk("upgrade has no RAM access", {ramREN, ramWEN}, 2'b00);
            env_drive();
            #1;
            if (dwait[c] == 1'b0) done++;
        end
        if (done < target) begin
            chk("transaction completes", done, target);
            do_reset();
        end else begin
            m_last = c[0];
            if (kind != K_WB) chk("snooper strobed", seen, 1);
            @(negedge CLK);
            clear_inputs();
        end
    endtask

    // Both cores post a victim writeback in the same cycle.
    task automatic run_dual_wb(input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
        int          first, second;
        logic [1:0]  done;
        logic [31:0] a [2];
        logic [31:0] d [2];
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        first  = (m_last == 1'b1) ? 0 : 1;
        second = 1 - first;
        push_exp((first == 0) ? 2'b10 : 2'b01, first, 0, 0, 1'b0, 1'b1, a[first], d[first]);
        push_exp((second == 0) ? 2'b10 : 2'b01, second, 0, 0, 1'b0, 1'b1, a[second], d[second]);
        @(negedge CLK);
        dWEN = 2'b11; cctrans = 2'b00; ccwrite = 2'b00;
        daddr[0] = a0; daddr[1] = a1; dstore[0] = d0; dstore[1] = d1;
        done = 2'b00;
        next_lat();
        env_drive();
        for (int cyc = 0; cyc < 300 && done != 2'b11; cyc++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) if (done[k]) dWEN[k] = 1'b0;
            chk("no snoop on dual writeback", ccwait, 2'b00);
            env_drive();
            #1;
            for (int k = 0; k < 2; k++) if (dwait[k] == 1'b0) done[k] = 1'b1;
        end
        if (done != 2'b11) begin
            chk("dual writeback completes", done, 2'b11);
            do_reset();
        end else begin
            m_last = second[0];
            @(negedge CLK);
            clear_inputs();
        end
    endtask

    initial begin
        exp_t e;
        wait (nRST === 1'b1);
        forever begin
            @(negedge CLK);
            #2;
            if (nRST === 1'b1 && dwait != 2'b11) begin
                if (sb.size() == 0) begin
                    chk("unexpected dwait pulse", dwait, 2'b11);
                end else begin
                    e = sb.pop_front();
                    chk("dwait pulse", dwait, e.dw);
                    chk("ramREN at completion", ramREN, e.ren);
                    chk("ramWEN at completion", ramWEN, e.wen);
                    if (e.ren || e.wen) chk("ramaddr", ramaddr, e.addr);
                    if (e.wen) chk("ramstore", ramstore, e.store);
                    if (e.chk_load) chk("dload", dload[e.core], e.load);
                end
            end
        end
    end

    initial begin
        int          c, k;
        logic [31:0] addr, s0, s1, wd;
        logic        excl, dirty;

        nRST = 1'b0;
        dREN = 2'b11; dWEN = 2'b11; cctrans = 2'b11; ccwrite = 2'b11;
        daddr[0] = $urandom; daddr[1] = $urandom; dstore[0] = $urandom; dstore[1] = $urandom;
        ramstate = 2'b10; ramload = $urandom;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("reset dwait", dwait, 2'b11);
        chk("reset ccwait", ccwait, 2'b00);
        chk("reset ccinv", ccinv, 2'b00);
        chk("reset ram enables", {ramREN, ramWEN}, 2'b00);
        chk("reset dload", dload, 64'h0);
        chk("reset ramaddr", ramaddr, 32'h0);
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;

        stall_mode = 0; lat_fixed = 2;
        mem[32'h100] = 32'hAA;
        mem[32'h104] = 32'hBB;
        run_txn(0, K_RD, 32'h100, 1'b0, 0, 0, 0, 1'b0, -1);
        run_txn(1, K_RD, 32'h200, 1'b1, 0, 32'h11, 32'h22, 1'b1, -1);
        run_txn(0, K_UPG, 32'h300, 1'b1, 0, 0, 0, 1'b0, -1);

        do_reset();
        run_dual_wb(32'h600, 32'h700, 32'h1111, 32'h2222);
        run_dual_wb(32'h608, 32'h708, 32'h3333, 32'h4444);

        stall_mode = 1; lat_fixed = 3;
        run_txn(1, K_WB, 32'h400, 1'b0, 32'hDEAD, 0, 0, 1'b0, -1);

        stall_mode = 0; lat_fixed = 20;
        run_txn(0, K_RD, 32'h500, 1'b0, 0, 0, 0, 1'b0, 5);

        stall_mode = 2; lat_fixed = -1;
        for (int i = 0; i < 40; i++) begin
            c     = $urandom_range(0, 1);
            k     = $urandom_range(0, 3);
            addr  = $urandom & 32'hFFFF_FFFC;
            s0    = $urandom;
            s1    = $urandom;
            wd    = $urandom;
            excl  = 1'($urandom_range(0, 1));
            dirty = 1'($urandom_range(0, 1));
            case (k)
                K_RD:    run_txn(c, K_RD, addr, excl, 0, s0, s1, dirty, -1);
                K_UPG:   run_txn(c, K_UPG, addr, 1'b1, 0, 0, 0, 1'b0, -1);
                K_WB:    run_txn(c, K_WB, addr, 1'b0, wd, 0, 0, 1'b0, -1);
                default: run_dual_wb(addr, addr ^ 32'h40, wd, s0);
            endcase
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
